// File: rtl/multicycle_controller.sv
// Control FSM for a multi-cycle RV32I datapath sharing one single-ported memory.
// The state, illegal and mem_err are registered. The strobes are decoded combinationally from the state and the inputs.
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 0,
  parameter int TMO_W       = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       br_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic       ir_wr,
  output logic       pc_wr,
  output logic       reg_wr,
  output logic [1:0] wb_sel,
  output logic       alu_a_sel,
  output logic [1:0] alu_b_sel,
  output logic [3:0] alu_op,
  output logic       instr_done,
  output logic       illegal,
  output logic       mem_err,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_TRAP    = 3'd5
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_PASS = 4'd10;

  state_t           state;
  logic [TMO_W-1:0] wait_cnt;
  logic             legal;
  logic             is_store;
  logic             is_mem;
  logic             is_jump;
  logic             timeout_hit;

  // sub_en selects SUB for funct3=000, sra_en selects SRA for funct3=101
  function automatic logic [3:0] f3_op(input logic [2:0] f3, input logic sub_en,
                                       input logic sra_en);
    case (f3)
      3'b000:  f3_op = sub_en ? ALU_SUB : ALU_ADD;
      3'b001:  f3_op = ALU_SLL;
      3'b010:  f3_op = ALU_SLT;
      3'b011:  f3_op = ALU_SLTU;
      3'b100:  f3_op = ALU_XOR;
      3'b101:  f3_op = sra_en ? ALU_SRA : ALU_SRL;
      3'b110:  f3_op = ALU_OR;
      default: f3_op = ALU_AND;
    endcase
  endfunction

  assign legal = (opcode == OP_R) || (opcode == OP_I) || (opcode == OP_LOAD) ||
                 (opcode == OP_STORE) || (opcode == OP_BR) || (opcode == OP_JAL) ||
                 (opcode == OP_JALR) || (opcode == OP_LUI) || (opcode == OP_AUIPC);
  assign is_store = (opcode == OP_STORE);
  assign is_mem   = (opcode == OP_LOAD) || is_store;
  assign is_jump  = (opcode == OP_BR) || (opcode == OP_JAL) || (opcode == OP_JALR);

  // MEM_TIMEOUT wait cycles are tolerated; the next still-unready cycle traps
  assign timeout_hit = (MEM_TIMEOUT != 0) && !mem_ready &&
                       (wait_cnt >= TMO_W'(MEM_TIMEOUT));

  assign state_o = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      illegal  <= 1'b0;
      mem_err  <= 1'b0;
    end else begin
      case (state)
        S_FETCH, S_MEM: begin
          if (mem_ready) begin
            if (state == S_FETCH) begin
              state <= S_DECODE;
            end else if (is_store) begin
              state    <= S_FETCH;
              wait_cnt <= '0;
            end else begin
              state <= S_WB;
            end
          end else if (timeout_hit) begin
            state   <= S_TRAP;
            mem_err <= 1'b1;
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_DECODE: begin
          if (legal) begin
            state <= S_EXECUTE;
          end else begin
            state   <= S_TRAP;
            illegal <= 1'b1;
          end
        end
        S_EXECUTE: begin
          wait_cnt <= '0;
          if (is_mem)       state <= S_MEM;
          else if (is_jump) state <= S_FETCH;
          else              state <= S_WB;
        end
        S_WB: begin
          state    <= S_FETCH;
          wait_cnt <= '0;
        end
        default: state <= S_TRAP;
      endcase
    end
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_sel   = 1'b0;
    ir_wr      = 1'b0;
    pc_wr      = 1'b0;
    reg_wr     = 1'b0;
    wb_sel     = 2'd0;
    alu_a_sel  = 1'b0;
    alu_b_sel  = 2'd0;
    alu_op     = ALU_ADD;
    instr_done = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          mem_req = 1'b1;
          ir_wr   = mem_ready;
        end
        S_EXECUTE: begin
          case (opcode)
            OP_R:  alu_op = f3_op(funct3, funct7_5, funct7_5);
            OP_I: begin
              alu_b_sel = 2'd1;
              alu_op    = f3_op(funct3, 1'b0, funct7_5);
            end
            OP_LUI: begin
              alu_b_sel = 2'd1;
              alu_op    = ALU_PASS;
            end
            OP_AUIPC: begin
              alu_a_sel = 1'b1;
              alu_b_sel = 2'd1;
            end
            OP_BR: begin
              alu_a_sel  = 1'b1;
              alu_b_sel  = br_taken ? 2'd1 : 2'd2;
              pc_wr      = 1'b1;
              instr_done = 1'b1;
            end
            OP_JAL, OP_JALR: begin
              alu_a_sel  = (opcode == OP_JAL);
              alu_b_sel  = 2'd1;
              pc_wr      = 1'b1;
              reg_wr     = 1'b1;
              wb_sel     = 2'd2;
              instr_done = 1'b1;
            end
            default: alu_b_sel = 2'd1;
          endcase
        end
        S_MEM: begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          mem_we   = is_store;
          if (mem_ready && is_store) begin
            alu_a_sel  = 1'b1;
            alu_b_sel  = 2'd2;
            pc_wr      = 1'b1;
            instr_done = 1'b1;
          end
        end
        S_WB: begin
          reg_wr     = 1'b1;
          wb_sel     = (opcode == OP_LOAD) ? 2'd1 : 2'd0;
          alu_a_sel  = 1'b1;
          alu_b_sel  = 2'd2;
          pc_wr      = 1'b1;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: a per-cycle vector table of instruction sequences,
// plus hand-written reset, illegal-opcode and memory-timeout sequences.
module tb_multicycle_controller;

  logic       clock;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       br_taken;
  logic       mem_ready;
  logic       mem_req, mem_we, addr_sel, ir_wr, pc_wr, reg_wr, instr_done;
  logic [1:0] wb_sel, alu_b_sel;
  logic       alu_a_sel;
  logic [3:0] alu_op;
  logic       illegal, mem_err;
  logic [2:0] state_o;

  int checks = 0;
  int errors = 0;

  multicycle_controller #(.MEM_TIMEOUT(4), .TMO_W(8)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .funct3(funct3),
    .funct7_5(funct7_5), .br_taken(br_taken), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_wr(ir_wr),
    .pc_wr(pc_wr), .reg_wr(reg_wr), .wb_sel(wb_sel), .alu_a_sel(alu_a_sel),
    .alu_b_sel(alu_b_sel), .alu_op(alu_op), .instr_done(instr_done),
    .illegal(illegal), .mem_err(mem_err), .state_o(state_o)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  // ctl bit order: {mem_req, mem_we, addr_sel, ir_wr, pc_wr, reg_wr, instr_done}
  localparam logic [6:0] C_NONE   = 7'b0000000;
  localparam logic [6:0] C_F_RDY  = 7'b1001000;
  localparam logic [6:0] C_F_WAIT = 7'b1000000;
  localparam logic [6:0] C_RETIRE = 7'b0000111;
  localparam logic [6:0] C_BR     = 7'b0000101;
  localparam logic [6:0] C_LD     = 7'b1010000;
  localparam logic [6:0] C_STW    = 7'b1110000;
  localparam logic [6:0] C_STR    = 7'b1110101;
  // alu bits: {alu_a_sel, alu_b_sel[1:0], alu_op[3:0]}
  localparam logic [6:0] M_ALL = 7'b1111111;
  localparam logic [6:0] M_BOP = 7'b0111111;
  localparam logic [6:0] A_PC4 = 7'b1_10_0000;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       brt;
    logic       rdy;
    logic [2:0] st;
    logic [6:0] ctl;
    logic [6:0] alu_m;
    logic [6:0] alu;
    logic       wb_chk;
    logic [1:0] wb;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                              input logic brt, input logic rdy, input logic [2:0] st,
                              input logic [6:0] ctl, input logic [6:0] alu_m,
                              input logic [6:0] alu, input logic wb_chk, input logic [1:0] wb);
    vec_t v;
    v.op = op; v.f3 = f3; v.f7 = f7; v.brt = brt; v.rdy = rdy; v.st = st;
    v.ctl = ctl; v.alu_m = alu_m; v.alu = alu; v.wb_chk = wb_chk; v.wb = wb;
    return v;
  endfunction

  // FETCH (zero-wait) and DECODE cycles of an instruction
  task automatic push_fd(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    vecs.push_back(mk(op, f3, f7, 1'b0, 1'b1, 3'd0, C_F_RDY, 7'd0, 7'd0, 1'b0, 2'd0));
    vecs.push_back(mk(op, f3, f7, 1'b0, 1'b1, 3'd1, C_NONE, 7'd0, 7'd0, 1'b0, 2'd0));
  endtask

  // EXECUTE then WB of an ALU-class instruction
  task automatic push_alu(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                          input logic [6:0] m, input logic [6:0] a);
    push_fd(op, f3, f7);
    vecs.push_back(mk(op, f3, f7, 1'b0, 1'b1, 3'd2, C_NONE, m, a, 1'b0, 2'd0));
    vecs.push_back(mk(op, f3, f7, 1'b0, 1'b1, 3'd4, C_RETIRE, M_ALL, A_PC4, 1'b1, 2'd0));
  endtask

  task automatic chk(input string nm, input int idx, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %h want %h", nm, idx, act, exp);
    end
  endtask

  function automatic logic [6:0] ctl_now();
    return {mem_req, mem_we, addr_sel, ir_wr, pc_wr, reg_wr, instr_done};
  endfunction

  // Called at a negedge: drive, check the pre-edge outputs, advance to the next negedge
  task automatic step(input vec_t v, input int idx);
    opcode = v.op; funct3 = v.f3; funct7_5 = v.f7; br_taken = v.brt; mem_ready = v.rdy;
    #1;
    chk("state", idx, 16'(state_o), 16'(v.st));
    chk("ctl", idx, 16'(ctl_now()), 16'(v.ctl));
    chk("flags", idx, 16'({illegal, mem_err}), 16'd0);
    if (v.alu_m != 7'd0)
      chk("alu", idx, 16'({alu_a_sel, alu_b_sel, alu_op} & v.alu_m), 16'(v.alu & v.alu_m));
    if (v.wb_chk) chk("wb_sel", idx, 16'(wb_sel), 16'(v.wb));
    @(negedge clock);
  endtask

  task automatic do_reset(input int idx);
    reset = 1'b1;
    mem_ready = 1'b1;
    @(negedge clock);
    #1;
    chk("rst_state", idx, 16'(state_o), 16'd0);
    chk("rst_ctl", idx, 16'(ctl_now()), 16'd0);
    chk("rst_flags", idx, 16'({illegal, mem_err}), 16'd0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; opcode = 7'd0; funct3 = 3'd0; funct7_5 = 1'b0;
    br_taken = 1'b0; mem_ready = 1'b0;
    repeat (2) @(negedge clock);

    push_alu(OP_R, 3'b000, 1'b0, M_ALL, 7'b0_00_0000);     // ADD
    vecs.push_back(mk(OP_R, 3'b000, 1'b1, 1'b0, 1'b0, 3'd0, C_F_WAIT, 7'd0, 7'd0, 1'b0, 2'd0));
    push_alu(OP_R, 3'b000, 1'b1, M_ALL, 7'b0_00_0001);     // SUB after one fetch wait
    push_alu(OP_R, 3'b101, 1'b1, M_ALL, 7'b0_00_0111);     // SRA
    push_alu(OP_R, 3'b110, 1'b0, M_ALL, 7'b0_00_1000);     // OR
    push_alu(OP_I, 3'b000, 1'b1, M_ALL, 7'b0_01_0000);     // ADDI, funct7_5 ignored
    push_alu(OP_I, 3'b101, 1'b1, M_ALL, 7'b0_01_0111);     // SRAI
    push_alu(OP_I, 3'b001, 1'b1, M_ALL, 7'b0_01_0010);     // SLLI
    push_alu(OP_I, 3'b011, 1'b0, M_ALL, 7'b0_01_0100);     // SLTIU
    push_alu(OP_LUI, 3'b000, 1'b0, M_BOP, 7'b0_01_1010);   // LUI
    push_alu(OP_AUIPC, 3'b000, 1'b0, M_ALL, 7'b1_01_0000); // AUIPC
    // LW with two wait cycles in MEM
    push_fd(OP_LD, 3'b010, 1'b0);
    vecs.push_back(mk(OP_LD, 3'b010, 1'b0, 1'b0, 1'b1, 3'd2, C_NONE, M_ALL, 7'b0_01_0000, 1'b0, 2'd0));
    vecs.push_back(mk(OP_LD, 3'b010, 1'b0, 1'b0, 1'b0, 3'd3, C_LD, 7'd0, 7'd0, 1'b0, 2'd0));
    vecs.push_back(mk(OP_LD, 3'b010, 1'b0, 1'b0, 1'b0, 3'd3, C_LD, 7'd0, 7'd0, 1'b0, 2'd0));
    vecs.push_back(mk(OP_LD, 3'b010, 1'b0, 1'b0, 1'b1, 3'd3, C_LD, 7'd0, 7'd0, 1'b0, 2'd0));
    vecs.push_back(mk(OP_LD, 3'b010, 1'b0, 1'b0, 1'b1, 3'd4, C_RETIRE, M_ALL, A_PC4, 1'b1, 2'd1));
    // SW with one wait cycle in MEM
    push_fd(OP_ST, 3'b010, 1'b0);
    vecs.push_back(mk(OP_ST, 3'b010, 1'b0, 1'b0, 1'b1, 3'd2, C_NONE, M_ALL, 7'b0_01_0000, 1'b0, 2'd0));
    vecs.push_back(mk(OP_ST, 3'b010, 1'b0, 1'b0, 1'b0, 3'd3, C_STW, 7'd0, 7'd0, 1'b0, 2'd0));
    vecs.push_back(mk(OP_ST, 3'b010, 1'b0, 1'b0, 1'b1, 3'd3, C_STR, M_ALL, A_PC4, 1'b0, 2'd0));
    // BEQ taken then not taken
    push_fd(OP_BR, 3'b000, 1'b0);
    vecs.push_back(mk(OP_BR, 3'b000, 1'b0, 1'b1, 1'b1, 3'd2, C_BR, M_ALL, 7'b1_01_0000, 1'b0, 2'd0));
    push_fd(OP_BR, 3'b000, 1'b0);
    vecs.push_back(mk(OP_BR, 3'b000, 1'b0, 1'b0, 1'b1, 3'd2, C_BR, M_ALL, 7'b1_10_0000, 1'b0, 2'd0));
    // JAL, JALR
    push_fd(OP_JAL, 3'b000, 1'b0);
    vecs.push_back(mk(OP_JAL, 3'b000, 1'b0, 1'b0, 1'b1, 3'd2, C_RETIRE, M_ALL, 7'b1_01_0000, 1'b1, 2'd2));
    push_fd(OP_JALR, 3'b000, 1'b0);
    vecs.push_back(mk(OP_JALR, 3'b000, 1'b0, 1'b0, 1'b1, 3'd2, C_RETIRE, M_ALL, 7'b0_01_0000, 1'b1, 2'd2));
    vecs.push_back(mk(OP_R, 3'b000, 1'b0, 1'b0, 1'b1, 3'd0, C_F_RDY, 7'd0, 7'd0, 1'b0, 2'd0));

    do_reset(0);
    foreach (vecs[i]) step(vecs[i], i);

    // Illegal opcode: trap, sticky flag, no strobes, reset clears
    do_reset(1);
    step(mk(OP_BAD, 3'd0, 1'b0, 1'b0, 1'b1, 3'd0, C_F_RDY, 7'd0, 7'd0, 1'b0, 2'd0), 1000);
    step(mk(OP_BAD, 3'd0, 1'b0, 1'b0, 1'b1, 3'd1, C_NONE, 7'd0, 7'd0, 1'b0, 2'd0), 1001);
    for (int k = 0; k < 20; k++) begin
      mem_ready = 1'($urandom_range(0, 1));
      br_taken  = 1'($urandom_range(0, 1));
      #1;
      chk("trap_state", k, 16'(state_o), 16'd5);
      chk("trap_ctl", k, 16'(ctl_now()), 16'd0);
      chk("trap_flags", k, 16'({illegal, mem_err}), 16'b10);
      @(negedge clock);
    end
    do_reset(2);

    // Fetch timeout: four tolerated waits, still not ready on the next cycle -> TRAP
    for (int k = 0; k < 5; k++)
      step(mk(OP_R, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, C_F_WAIT, 7'd0, 7'd0, 1'b0, 2'd0), 2000 + k);
    #1;
    chk("tmo_state", 0, 16'(state_o), 16'd5);
    chk("tmo_flags", 0, 16'({illegal, mem_err}), 16'b01);
    chk("tmo_ctl", 0, 16'(ctl_now()), 16'd0);
    @(negedge clock);
    do_reset(3);

    // Same, but memory answers in the cycle the timeout would fire
    for (int k = 0; k < 4; k++)
      step(mk(OP_R, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, C_F_WAIT, 7'd0, 7'd0, 1'b0, 2'd0), 3000 + k);
    step(mk(OP_R, 3'd0, 1'b0, 1'b0, 1'b1, 3'd0, C_F_RDY, 7'd0, 7'd0, 1'b0, 2'd0), 3004);
    #1;
    chk("notmo_state", 0, 16'(state_o), 16'd1);
    chk("notmo_flags", 0, 16'({illegal, mem_err}), 16'd0);
    @(negedge clock);
    do_reset(4);

    // Reset asserted in the middle of a store's MEM phase
    push_fd(OP_ST, 3'b010, 1'b0);
    vecs.delete();
    push_fd(OP_ST, 3'b010, 1'b0);
    step(vecs[0], 4000);
    step(vecs[1], 4001);
    step(mk(OP_ST, 3'b010, 1'b0, 1'b0, 1'b1, 3'd2, C_NONE, 7'd0, 7'd0, 1'b0, 2'd0), 4002);
    step(mk(OP_ST, 3'b010, 1'b0, 1'b0, 1'b0, 3'd3, C_STW, 7'd0, 7'd0, 1'b0, 2'd0), 4003);
    #1;
    chk("mid_req", 0, 16'(mem_req), 16'd1);
    reset = 1'b1;
    #1;
    chk("mid_state", 0, 16'(state_o), 16'd0);
    chk("mid_ctl", 0, 16'(ctl_now()), 16'd0);
    mem_ready = 1'b1;
    #1;
    chk("mid_ctl_rdy", 0, 16'(ctl_now()), 16'd0);
    @(negedge clock);
    #1;
    chk("mid_hold_ctl", 0, 16'(ctl_now()), 16'd0);
    @(negedge clock);
    reset = 1'b0;
    step(mk(OP_ST, 3'b010, 1'b0, 1'b0, 1'b1, 3'd0, C_F_RDY, 7'd0, 7'd0, 1'b0, 2'd0), 4004);
    step(mk(OP_ST, 3'b010, 1'b0, 1'b0, 1'b1, 3'd1, C_NONE, 7'd0, 7'd0, 1'b0, 2'd0), 4005);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
